// File: rtl/step_ctrl_pkg.sv
// Shared types and build constants for the CPU step controller.
// Both the top level and the button debouncer import this package.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } step_state_e;

    // Short debounce for simulation; the board build needs ~10 ms at the CPU clock.
    localparam int DEBOUNCE_CYCLES_SIM   = 16;
    localparam int DEBOUNCE_CYCLES_BOARD = 1000000;
    localparam int RUN_DIV_DEFAULT       = 4;

    function automatic int count_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/cpu_step_controller_if.sv
// Board/core facing signals of the step controller.
// The master side drives buttons and halt/clear; the slave side is the controller.
interface cpu_step_controller_if;

    logic        step_btn_i;
    logic        run_mode_i;
    logic        halt_i;
    logic        clear_i;
    logic        cpu_en_o;
    logic [31:0] step_count_o;
    logic        halted_o;
    logic [1:0]  state_o;

    modport master (
        output step_btn_i,
        output run_mode_i,
        output halt_i,
        output clear_i,
        input  cpu_en_o,
        input  step_count_o,
        input  halted_o,
        input  state_o
    );

    modport slave (
        input  step_btn_i,
        input  run_mode_i,
        input  halt_i,
        input  clear_i,
        output cpu_en_o,
        output step_count_o,
        output halted_o,
        output state_o
    );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-level debounce counter and rising-edge pulse
// for a raw mechanical button.
module button_debouncer
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam int              DB_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic            db_prev_q, db_prev_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Any disagreement shorter than DEBOUNCE_CYCLES restarts the count.
    always_comb begin
        sync1_d   = btn_i;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_cnt_d  = db_cnt_q;
        db_prev_d = db_q;
        if (sync2_q == db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_d     = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
        end
    end

    assign rise_o = db_q & ~db_prev_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Produces the single-cycle CPU clock enable from a debounced step button or a
// free-running divider, latches halt requests and counts executed steps.
module cpu_step_controller
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int RUN_DIV         = RUN_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetC,
    cpu_step_controller_if.slave  bus
);

    localparam int              RD_W     = count_width(RUN_DIV);
    localparam logic [RD_W-1:0] RUN_LAST = RD_W'(RUN_DIV - 1);

    logic            step_req;
    logic            run_s;

    logic            run_sync1_q, run_sync1_d;
    logic            run_sync2_q, run_sync2_d;
    step_state_e     state_q, state_d;
    logic [RD_W-1:0] run_cnt_q, run_cnt_d;
    logic            cpu_en_q, cpu_en_d;
    logic            halted_q, halted_d;
    logic [31:0]     step_count_q, step_count_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk    (clk),
        .rst_n  (resetC),
        .btn_i  (bus.step_btn_i),
        .rise_o (step_req)
    );

    assign run_s = run_sync2_q;

    // Halt overrides everything; a step edge seen outside IDLE is simply dropped.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        cpu_en_d  = 1'b0;
        if (bus.halt_i) begin
            state_d   = ST_HALT;
            run_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_s) begin
                        state_d   = ST_RUN;
                        run_cnt_d = '0;
                    end else if (step_req) begin
                        cpu_en_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_s) begin
                        state_d   = ST_IDLE;
                        run_cnt_d = '0;
                    end else if (run_cnt_q == RUN_LAST) begin
                        cpu_en_d  = 1'b1;
                        run_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end
                ST_HALT: begin
                    if (bus.clear_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    run_cnt_d = '0;
                end
            endcase
        end
        halted_d = (state_d == ST_HALT);
    end

    // Clear takes precedence over the increment from an enable in the same cycle.
    always_comb begin
        run_sync1_d  = bus.run_mode_i;
        run_sync2_d  = run_sync1_q;
        step_count_d = step_count_q;
        if (bus.clear_i) begin
            step_count_d = '0;
        end else if (cpu_en_q) begin
            step_count_d = step_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetC) begin
        if (!resetC) begin
            run_sync1_q  <= 1'b0;
            run_sync2_q  <= 1'b0;
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            cpu_en_q     <= 1'b0;
            halted_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            run_sync1_q  <= run_sync1_d;
            run_sync2_q  <= run_sync2_d;
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            cpu_en_q     <= cpu_en_d;
            halted_q     <= halted_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.cpu_en_o     = cpu_en_q;
    assign bus.step_count_o = step_count_q;
    assign bus.halted_o     = halted_q;
    assign bus.state_o      = state_q;

endmodule
